// File: rtl/counter_pkg.sv
// Shared definitions for the toggle/up/down/load counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop storage bit: flips on t, cleared by synchronous rst.
// 1-cycle latency; no backpressure.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/toggle_counter.sv
// Multi-mode counter (toggle/up/down/load) built from T flip-flops, with terminal-count pulse.
// 1-cycle latency for q and tc; no backpressure, en=0 freezes all state.
module toggle_counter
  import counter_pkg::*;
#(
  parameter int                WIDTH    = 8,
  parameter longint unsigned   MODULUS  = 64'd1 << WIDTH,
  parameter int                SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_vec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  // Limit compares are done one bit wider so MODULUS = 2**WIDTH cannot overflow.
  localparam logic [WIDTH:0]   MAXV  = (WIDTH+1)'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] MAX_Q = MAXV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = 1;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] mask;
  logic             tc_nxt;

  assign q_ext  = {1'b0, q};
  assign lv_ext = {1'b0, load_val};

  always_comb begin
    nxt    = q;
    tc_nxt = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_TOGGLE: nxt = q ^ t_vec;
        MODE_UP: begin
          if (q_ext >= MAXV) begin
            nxt    = (SATURATE != 0) ? MAX_Q : '0;
            tc_nxt = 1'b1;
          end else begin
            nxt = q + ONE;
          end
        end
        MODE_DOWN: begin
          if (q_ext == '0) begin
            nxt    = (SATURATE != 0) ? '0 : MAX_Q;
            tc_nxt = 1'b1;
          end else if (q_ext > MAXV) begin
            // Out-of-range value left behind by TOGGLE snaps back to the top.
            nxt = MAX_Q;
          end else begin
            nxt = q - ONE;
          end
        end
        MODE_LOAD: nxt = (lv_ext > MAXV) ? MAX_Q : load_val;
        default:   nxt = q;
      endcase
    end
    mask = q ^ nxt;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (mask[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) tc <= 1'b0;
    else     tc <= tc_nxt;
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_toggle_counter.sv
// Directed vector table plus randomized run against an arithmetic reference model,
// over three instances: modulus 10 wrap, modulus 10 saturate, full 4-bit modulus.
module tb_toggle_counter;
  import counter_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t_vec;
  logic [3:0] load_val;
  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       z0, z1, z2;

  int checks = 0;
  int errors = 0;

  int  m_q0, m_q1, m_q2;
  bit  m_tc0, m_tc1, m_tc2;

  toggle_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t_vec(t_vec),
    .load_val(load_val), .q(q0), .tc(tc0), .zero(z0)
  );

  toggle_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t_vec(t_vec),
    .load_val(load_val), .q(q1), .tc(tc1), .zero(z1)
  );

  toggle_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t_vec(t_vec),
    .load_val(load_val), .q(q2), .tc(tc2), .zero(z2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] tv;
    logic [3:0] lv;
    int         q0;
    bit         tc0;
    int         q1;
    bit         tc1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [1:0] md,
                     input logic [3:0] tv, input logic [3:0] lv,
                     input int eq0, input bit etc0, input int eq1, input bit etc1);
    vec_t v;
    v.rst = r; v.en = e; v.mode = md; v.tv = tv; v.lv = lv;
    v.q0 = eq0; v.tc0 = etc0; v.q1 = eq1; v.tc1 = etc1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference behaviour stated directly in terms of counter value and limit.
  function automatic int ref_next(input int cur, input int modulus, input bit sat,
                                  input bit r, input bit e, input int md,
                                  input int tv, input int lv, output bit tc_o);
    int top = modulus - 1;
    tc_o = 1'b0;
    if (r) return 0;
    if (!e) return cur;
    case (md)
      0: return cur ^ tv;
      1: begin
        if (cur >= top) begin tc_o = 1'b1; return sat ? top : 0; end
        return cur + 1;
      end
      2: begin
        if (cur == 0) begin tc_o = 1'b1; return sat ? 0 : top; end
        if (cur > top) return top;
        return cur - 1;
      end
      default: return (lv < top) ? lv : top;
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [3:0] tv, input logic [3:0] lv);
    int n0, n1, n2;
    bit t0, t1, t2;
    rst = r; en = e; mode = md; t_vec = tv; load_val = lv;
    n0 = ref_next(m_q0, 10, 1'b0, r, e, int'(md), int'(tv), int'(lv), t0);
    n1 = ref_next(m_q1, 10, 1'b1, r, e, int'(md), int'(tv), int'(lv), t1);
    n2 = ref_next(m_q2, 16, 1'b0, r, e, int'(md), int'(tv), int'(lv), t2);
    @(posedge clk);
    #1;
    m_q0 = n0; m_q1 = n1; m_q2 = n2;
    m_tc0 = t0; m_tc1 = t1; m_tc2 = t2;
  endtask

  task automatic check_model(input string tag);
    check({tag, " model q wrap10"}, 32'(q0), 32'(m_q0));
    check({tag, " model tc wrap10"}, 32'(tc0), 32'(m_tc0));
    check({tag, " model zero wrap10"}, 32'(z0), 32'(m_q0 == 0));
    check({tag, " model q sat10"}, 32'(q1), 32'(m_q1));
    check({tag, " model tc sat10"}, 32'(tc1), 32'(m_tc1));
    check({tag, " model zero sat10"}, 32'(z1), 32'(m_q1 == 0));
    check({tag, " model q full16"}, 32'(q2), 32'(m_q2));
    check({tag, " model tc full16"}, 32'(tc2), 32'(m_tc2));
    check({tag, " model zero full16"}, 32'(z2), 32'(m_q2 == 0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_TOGGLE; t_vec = '0; load_val = '0;
    m_q0 = 0; m_q1 = 0; m_q2 = 0; m_tc0 = 0; m_tc1 = 0; m_tc2 = 0;

    // reset with en=1, mode=UP
    add(1, 1, MODE_UP, 0, 0, 0, 0, 0, 0);
    add(1, 1, MODE_UP, 0, 0, 0, 0, 0, 0);
    // up-wrap from 0
    for (int i = 1; i <= 9; i++) add(0, 1, MODE_UP, 0, 0, i, 0, i, 0);
    add(0, 1, MODE_UP, 0, 0, 0, 1, 9, 1);
    // load 7 then down past zero
    add(0, 1, MODE_LOAD, 0, 7, 7, 0, 7, 0);
    for (int i = 6; i >= 0; i--) add(0, 1, MODE_DOWN, 0, 0, i, 0, i, 0);
    add(0, 1, MODE_DOWN, 0, 0, 9, 1, 0, 1);
    add(0, 1, MODE_DOWN, 0, 0, 8, 0, 0, 1);
    // toggle out of range, then clamp via DOWN and LOAD
    add(1, 1, MODE_UP, 0, 0, 0, 0, 0, 0);
    add(0, 1, MODE_TOGGLE, 4'hF, 0, 15, 0, 15, 0);
    add(0, 1, MODE_DOWN, 0, 0, 9, 0, 9, 0);
    add(0, 1, MODE_LOAD, 0, 12, 9, 0, 9, 0);
    // enable low holds; reset beats load
    for (int i = 0; i < 3; i++) add(0, 0, MODE_UP, 0, 0, 9, 0, 9, 0);
    add(1, 1, MODE_LOAD, 0, 5, 0, 0, 0, 0);
    // mid-count reset
    for (int i = 1; i <= 6; i++) add(0, 1, MODE_UP, 0, 0, i, 0, i, 0);
    add(1, 1, MODE_UP, 0, 0, 0, 0, 0, 0);
    add(0, 1, MODE_UP, 0, 0, 1, 0, 1, 0);
    add(0, 1, MODE_UP, 0, 0, 2, 0, 2, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].tv, vecs[i].lv);
      check($sformatf("vec%0d q wrap10", i), 32'(q0), 32'(vecs[i].q0));
      check($sformatf("vec%0d tc wrap10", i), 32'(tc0), 32'(vecs[i].tc0));
      check($sformatf("vec%0d zero wrap10", i), 32'(z0), 32'(vecs[i].q0 == 0));
      check($sformatf("vec%0d q sat10", i), 32'(q1), 32'(vecs[i].q1));
      check($sformatf("vec%0d tc sat10", i), 32'(tc1), 32'(vecs[i].tc1));
      check($sformatf("vec%0d zero sat10", i), 32'(z1), 32'(vecs[i].q1 == 0));
      check_model($sformatf("vec%0d", i));
    end

    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
